// File: rtl/coding_style_pkg.sv
// Shared widths and helpers for the coding_style demo slice.
// Imported by the interface, the split adder and the top.
package coding_style_pkg;

  localparam int DW  = 64;
  localparam int PSW = 32;
  localparam int EW  = 3;
  localparam int XW  = 1 << EW;
  localparam int HW  = DW / 2;

  function automatic logic [XW-1:0] onehot(
    input logic [EW-1:0] sel
  );
    return XW'(1) << sel;
  endfunction

  function automatic logic parity(
    input logic [PSW-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/coding_style_if.sv
// Adder operand/result bundle shared by the top,
// the split adder and the bench.
interface coding_style_if;
  import coding_style_pkg::*;

  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] sum;

  modport master (
    output a,
    output b,
    input  sum
  );

  modport slave (
    input  a,
    input  b,
    output sum
  );

endinterface

// File: rtl/coding_style_add64_pipe.sv
// Two-stage split adder: low half plus carry first,
// upper half and final concatenation second.
module coding_style_add64_pipe
  import coding_style_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  coding_style_if.slave  bus
);

  logic [HW:0]   lo_q;
  logic [HW-1:0] a_hi_q;
  logic [HW-1:0] b_hi_q;
  logic [HW-1:0] hi;

  always_comb begin
    hi = a_hi_q + b_hi_q + HW'(lo_q[HW]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q   <= '0;
      a_hi_q <= '0;
      b_hi_q <= '0;
    end else begin
      lo_q   <= {1'b0, bus.a[HW-1:0]}
              + {1'b0, bus.b[HW-1:0]};
      a_hi_q <= bus.a[DW-1:HW];
      b_hi_q <= bus.b[DW-1:HW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.sum <= '0;
    end else begin
      bus.sum <= {hi, lo_q[HW-1:0]};
    end
  end

endmodule

// File: rtl/coding_style.sv
// Side-by-side arithmetic, decode, part-select and
// toggle styles; every output depends only on its own inputs.
module coding_style
  import coding_style_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   sum1,
  output logic [DW-1:0]   sum2,
  output logic [DW-1:0]   sum3,
  input  logic [EW-1:0]   exp_in,
  output logic [XW-1:0]   exp_out1,
  output logic [XW-1:0]   exp_out2,
  output logic            port_a,
  input  logic [PSW-1:0]  part_sel_in,
  output logic [0:PSW-1]  part_sel_out,
  input  logic            always_block_in,
  output logic            always_block_out
);

  coding_style_if add_bus ();

  assign add_bus.a = a;
  assign add_bus.b = b;
  assign sum3      = add_bus.sum;

  coding_style_add64_pipe u_pipe (
    .clk   (clk),
    .reset (reset),
    .bus   (add_bus)
  );

  assign sum1     = a + b;
  assign exp_out1 = onehot(exp_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum2 <= '0;
    end else begin
      sum2 <= a + b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_out2 <= '0;
    end else begin
      case (exp_in)
        3'd0:    exp_out2 <= 8'h01;
        3'd1:    exp_out2 <= 8'h02;
        3'd2:    exp_out2 <= 8'h04;
        3'd3:    exp_out2 <= 8'h08;
        3'd4:    exp_out2 <= 8'h10;
        3'd5:    exp_out2 <= 8'h20;
        3'd6:    exp_out2 <= 8'h40;
        3'd7:    exp_out2 <= 8'h80;
        default: exp_out2 <= 8'h00;
      endcase
    end
  end

  // Index-wise copy into an ascending range bit-reverses the value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      part_sel_out <= '0;
      port_a       <= 1'b0;
    end else begin
      for (int k = 0; k < PSW; k++) begin
        part_sel_out[k] <= part_sel_in[k];
      end
      port_a <= parity(part_sel_in);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      always_block_out <= 1'b0;
    end else if (always_block_in) begin
      always_block_out <= ~always_block_out;
    end
  end

endmodule

// File: tb/tb_coding_style.sv
// Directed bench for coding_style: adders, decoders,
// part-select, toggle register and async reset.
module tb_coding_style;
  import coding_style_pkg::*;

  logic           clk;
  logic           reset;
  logic [DW-1:0]  sum1;
  logic [DW-1:0]  sum2;
  logic [EW-1:0]  exp_in;
  logic [XW-1:0]  exp_out1;
  logic [XW-1:0]  exp_out2;
  logic           port_a;
  logic [PSW-1:0] ps_in;
  logic [0:PSW-1] ps_out;
  logic           ab_in;
  logic           ab_out;

  int total;
  int passed;

  coding_style_if bus ();

  coding_style dut (
    .clk              (clk),
    .reset            (reset),
    .a                (bus.a),
    .b                (bus.b),
    .sum1             (sum1),
    .sum2             (sum2),
    .sum3             (bus.sum),
    .exp_in           (exp_in),
    .exp_out1         (exp_out1),
    .exp_out2         (exp_out2),
    .port_a           (port_a),
    .part_sel_in      (ps_in),
    .part_sel_out     (ps_out),
    .always_block_in  (ab_in),
    .always_block_out (ab_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp_v
  );
    total++;
    assert (obs === exp_v) passed++;
    else begin
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  oh;
    logic [31:0] pexp;
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    bus.a  = 64'd1;
    bus.b  = 64'd1;
    exp_in = 3'd3;
    ps_in  = 32'd1;
    ab_in  = 1'b1;
    #2 reset = 1'b0;

    repeat (10) tick();
    chk("rst_sum2",  sum2,     64'd0);
    chk("rst_sum3",  bus.sum,  64'd0);
    chk("rst_exp2",  exp_out2, 64'd0);
    chk("rst_porta", port_a,   64'd0);
    chk("rst_psout", ps_out,   64'd0);
    chk("rst_about", ab_out,   64'd0);
    chk("rst_sum1",  sum1,     64'd2);
    chk("rst_exp1",  exp_out1, 64'h08);

    reset = 1'b1;
    ab_in = 1'b0;
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.b = 64'd1;
    #1 chk("wrap_sum1", sum1, 64'd0);
    tick();
    chk("wrap_sum2", sum2, 64'd0);
    bus.a = 64'h0000_0000_FFFF_FFFF;
    bus.b = 64'd1;
    #1 chk("mid_sum1", sum1, 64'h0000_0001_0000_0000);
    tick();
    chk("wrap_sum3", bus.sum, 64'd0);
    chk("mid_sum2",  sum2, 64'h0000_0001_0000_0000);
    bus.a = 64'h0000_0001_0000_0002;
    bus.b = 64'h0000_0003_0000_0004;
    tick();
    chk("mid_sum3",  bus.sum, 64'h0000_0001_0000_0000);
    chk("v3_sum2",   sum2, 64'h0000_0004_0000_0006);
    bus.a = 64'h8000_0000_8000_0000;
    bus.b = 64'h8000_0000_8000_0000;
    tick();
    chk("v3_sum3",   bus.sum, 64'h0000_0004_0000_0006);
    chk("v4_sum2",   sum2, 64'h0000_0001_0000_0000);
    tick();
    chk("v4_sum3",   bus.sum, 64'h0000_0001_0000_0000);

    for (int i = 0; i < 8; i++) begin
      exp_in = 3'(i);
      oh = 8'd1 << i;
      #1 chk($sformatf("exp1_%0d", i), exp_out1, oh);
      tick();
      chk($sformatf("exp2_%0d", i), exp_out2, oh);
    end

    ps_in = 32'd1;
    for (int i = 0; i < 34; i++) begin
      tick();
      pexp = (i < 32) ? (32'h8000_0000 >> i) : 32'd0;
      chk($sformatf("psout_%0d", i), ps_out, pexp);
      chk($sformatf("porta_%0d", i), port_a,
          (i < 32) ? 64'd1 : 64'd0);
      ps_in = ps_in << 1;
    end

    chk("tog_init", ab_out, 64'd0);
    ab_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("tog_%0d", i), ab_out,
          (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    ab_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_%0d", i), ab_out, 64'd0);
    end

    bus.a  = 64'd5;
    bus.b  = 64'd6;
    exp_in = 3'd5;
    ps_in  = 32'h0000_0003;
    ab_in  = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_sum3",  bus.sum,  64'd11);
    chk("pre_about", ab_out,   64'd1);
    chk("pre_psout", ps_out,   64'hC000_0000);
    #3 reset = 1'b0;
    #1;
    chk("arst_sum2",  sum2,     64'd0);
    chk("arst_sum3",  bus.sum,  64'd0);
    chk("arst_exp2",  exp_out2, 64'd0);
    chk("arst_porta", port_a,   64'd0);
    chk("arst_psout", ps_out,   64'd0);
    chk("arst_about", ab_out,   64'd0);
    chk("arst_sum1",  sum1,     64'd11);
    chk("arst_exp1",  exp_out1, 64'h20);

    reset = 1'b1;
    tick();
    chk("rel_sum3_0", bus.sum, 64'd0);
    tick();
    chk("rel_sum3_1", bus.sum, 64'd11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
